// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner, one-outstanding word fetcher and in-order instruction queue
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   chip_enabled        gates issue of new fetch requests only
//   mem_req_*           fetch request toward instruction memory (valid/ready, word address)
//   mem_resp_*          single-cycle response pulse with fetched word
//   inst_*/instruction  queue head toward the decoder (valid/ready, word + its PC)
//   redirect_*          branch/jump redirect pulse with new target PC
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 17,
    parameter int                    LEN        = 32,
    parameter int                    IQ_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  chip_enabled,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [LEN-1:0]        mem_resp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [LEN-1:0]        instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target
);

    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(IQ_DEPTH);
    localparam logic [CW-1:0]         ONE_C   = CW'(1);
    localparam logic [PW-1:0]         ONE_P   = PW'(1);
    localparam logic [ADDR_WIDTH-1:0] WORD_C  = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [LEN-1:0]        iq_inst_q [IQ_DEPTH];
    logic [ADDR_WIDTH-1:0] iq_pc_q   [IQ_DEPTH];

    logic                  req_fire;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  unused_tgt_bits;

    assign target_pc       = {redirect_target[ADDR_WIDTH-1:2], 2'b00};
    assign unused_tgt_bits = ^redirect_target[1:0];

    assign mem_req_addr = fetch_pc_q;
    assign inst_valid   = (count_q != '0);
    assign instruction  = iq_inst_q[head_q];
    assign inst_pc      = iq_pc_q[head_q];

    always_comb begin
        // A redirect cycle never issues, so no request can carry the stale PC.
        mem_req_valid = rst && (state_q == S_IDLE) && chip_enabled
                        && (count_q < DEPTH_C) && !redirect_valid;
        req_fire      = mem_req_valid && mem_req_ready;
        push          = (state_q == S_WAIT) && mem_resp_valid && !redirect_valid;
        pop           = inst_valid && inst_ready && !redirect_valid;

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (req_fire) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + WORD_C;
        end

        case (state_q)
            S_IDLE:    if (req_fire) state_d = S_WAIT;
            // Response wins over redirect: with the response in hand nothing
            // remains in flight, so the discard state is not needed.
            S_WAIT:    if (mem_resp_valid) state_d = S_IDLE;
                       else if (redirect_valid) state_d = S_DISCARD;
            S_DISCARD: if (mem_resp_valid) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (push) tail_d = tail_q + ONE_P;
        if (pop)  head_d = head_q + ONE_P;
        case ({push, pop})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = target_pc;
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_inst_q[i] <= '0;
                iq_pc_q[i]   <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            if (push) begin
                iq_inst_q[tail_q] <= mem_resp_data;
                iq_pc_q[tail_q]   <= req_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    localparam int AW  = 17;
    localparam int LEN = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          chip_enabled = 1'b1;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [AW-1:0] mem_req_addr;
    logic          mem_resp_valid = 1'b0;
    logic [LEN-1:0] mem_resp_data = '0;
    logic          inst_valid;
    logic          inst_ready = 1'b0;
    logic [LEN-1:0] instruction;
    logic [AW-1:0] inst_pc;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_target = '0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .chip_enabled    (chip_enabled),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_resp_valid  (mem_resp_valid),
        .mem_resp_data   (mem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instruction     (instruction),
        .inst_pc         (inst_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    int errors = 0;
    int checks = 0;

    // Reference: the decoder must see consecutive PCs starting at the last
    // redirect (or reset) target, each carrying memory[pc] = pc*2; requests
    // must likewise walk forward from that target one word at a time.
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] exp_req_pc;
    bit            pend;
    int            pend_cnt;
    logic [AW-1:0] pend_addr;
    int            lat = 1;
    int            nreq = 0;
    int            npop = 0;
    bit            last_fire;
    bit            last_pop;
    logic [AW-1:0] last_pop_pc;
    bit            prev_redirect;
    bit            prev_hold;
    logic [AW-1:0] prev_addr;

    function automatic logic [LEN-1:0] mem_word(input logic [AW-1:0] a);
        return LEN'(a) * 2;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        exp_pc        = '0;
        exp_req_pc    = '0;
        pend          = 1'b0;
        prev_redirect = 1'b0;
        prev_hold     = 1'b0;
    endtask

    // One clock: entered at a negedge with inputs applied; returns at the
    // next negedge with the memory response (if due) driven.
    task automatic cycle();
        bit fire, pop, redir;
        #1;
        fire  = mem_req_valid && mem_req_ready;
        pop   = inst_valid && inst_ready;
        redir = redirect_valid;
        if (prev_redirect) chk("valid_after_redirect", 64'(inst_valid), 0);
        if (prev_hold && chip_enabled && !redir) begin
            chk("req_held", 64'(mem_req_valid), 1);
            chk("req_addr_stable", 64'(mem_req_addr), 64'(prev_addr));
        end
        if (redir) chk("no_req_on_redirect", 64'(mem_req_valid), 0);
        if (fire) begin
            chk("single_outstanding", 64'(pend), 0);
            chk("req_addr", 64'(mem_req_addr), 64'(exp_req_pc));
            exp_req_pc = exp_req_pc + 4;
            pend       = 1'b1;
            pend_cnt   = lat;
            pend_addr  = mem_req_addr;
            nreq++;
        end
        last_pop = pop && !redir;
        if (last_pop) begin
            chk("inst_pc", 64'(inst_pc), 64'(exp_pc));
            chk("instruction", 64'(instruction), 64'(mem_word(exp_pc)));
            last_pop_pc = inst_pc;
            exp_pc      = exp_pc + 4;
            npop++;
        end
        if (redir) begin
            exp_pc     = {redirect_target[AW-1:2], 2'b00};
            exp_req_pc = {redirect_target[AW-1:2], 2'b00};
        end
        prev_redirect = redir;
        prev_hold     = mem_req_valid && !mem_req_ready && !redir;
        prev_addr     = mem_req_addr;
        last_fire     = fire;
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(pend_addr);
                pend           = 1'b0;
            end
        end
    endtask

    task automatic wait_fire(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            cycle();
            seen = last_fire;
        end
        chk(tag, 64'(seen), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 0);
        chk({tag, "_req_addr"}, 64'(mem_req_addr), 0);
        chk({tag, "_inst_valid"}, 64'(inst_valid), 0);
        chk({tag, "_instruction"}, 64'(instruction), 0);
        chk({tag, "_inst_pc"}, 64'(inst_pc), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        check_reset_outputs("rst");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit got;
        int p0;
        reset_model();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b1;

        // Streaming fetch, 1-cycle memory, decoder always ready
        lat = 1; mem_req_ready = 1'b1; inst_ready = 1'b1;
        #1;
        chk("t1_first_req_valid", 64'(mem_req_valid), 1);
        chk("t1_first_req_addr", 64'(mem_req_addr), 0);
        cycle();
        cycle();
        #1;
        chk("t1_first_latency", 64'(inst_valid), 1);
        chk("t1_first_pc", 64'(inst_pc), 0);
        for (int i = 0; i < 7; i++) cycle();
        chk("t1_three_delivered", 64'(npop >= 3), 1);

        // Queue fills with decoder stalled, then one pop frees a slot
        pulse_reset();
        inst_ready = 1'b0; nreq = 0;
        for (int i = 0; i < 20; i++) cycle();
        #1;
        chk("t2_req_count", 64'(nreq), 4);
        chk("t2_req_stopped", 64'(mem_req_valid), 0);
        chk("t2_head_valid", 64'(inst_valid), 1);
        inst_ready = 1'b1;
        cycle();
        #1;
        chk("t2_slot_req_valid", 64'(mem_req_valid), 1);
        chk("t2_slot_req_addr", 64'(mem_req_addr), 16);

        // Redirect with 3 entries queued and nothing outstanding
        mem_req_ready = 1'b0; inst_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 17'h103;
        cycle();
        #1;
        chk("t3_flushed", 64'(inst_valid), 0);
        chk("t3_next_addr", 64'(mem_req_addr), 17'h100);
        mem_req_ready = 1'b1; inst_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            got = last_pop;
        end
        chk("t3_got_pop", 64'(got), 1);
        chk("t3_first_pc", 64'(last_pop_pc), 17'h100);

        // Redirect while waiting; response arrives two cycles later
        lat = 3;
        wait_fire("t4_fire");
        redirect_valid = 1'b1; redirect_target = 17'h200;
        cycle();
        #1;
        chk("t4_discard_a", 64'(mem_req_valid), 0);
        cycle();
        #1;
        chk("t4_discard_b", 64'(mem_req_valid), 0);
        cycle();
        #1;
        chk("t4_next_req_valid", 64'(mem_req_valid), 1);
        chk("t4_next_req_addr", 64'(mem_req_addr), 17'h200);
        chk("t4_dropped", 64'(inst_valid), 0);

        // Redirect coincident with the response
        lat = 1;
        wait_fire("t5_fire");
        redirect_valid = 1'b1; redirect_target = 17'h300;
        cycle();
        #1;
        chk("t5_not_enqueued", 64'(inst_valid), 0);
        chk("t5_req_valid", 64'(mem_req_valid), 1);
        chk("t5_req_addr", 64'(mem_req_addr), 17'h300);
        for (int i = 0; i < 6; i++) cycle();

        // Randomized traffic against the reference
        p0 = npop;
        for (int i = 0; i < 800; i++) begin
            inst_ready    = ($urandom_range(0, 9) < 7);
            mem_req_ready = ($urandom_range(0, 9) < 7);
            chip_enabled  = ($urandom_range(0, 9) != 0);
            lat           = $urandom_range(1, 3);
            if ($urandom_range(0, 24) == 0) begin
                redirect_valid  = 1'b1;
                redirect_target = AW'($urandom);
            end
            cycle();
        end
        chk("rand_progress", 64'((npop - p0) > 40), 1);

        // Async reset mid-wait, then a stale response while idle
        chip_enabled = 1'b1; mem_req_ready = 1'b1; inst_ready = 1'b0; lat = 3;
        for (int i = 0; i < 8; i++) cycle();
        inst_ready = 1'b1;
        wait_fire("t6_fire");
        #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        chip_enabled = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hdead_beef;
        cycle();
        #1;
        chk("t6_stale_ignored", 64'(inst_valid), 0);
        chk("t6_no_req", 64'(mem_req_valid), 0);
        chk("t6_addr_reset_pc", 64'(mem_req_addr), 0);
        chip_enabled = 1'b1; lat = 1;
        p0 = npop;
        cycle();
        chk("t6_restart_fire", 64'(last_fire), 1);
        for (int i = 0; i < 8; i++) cycle();
        chk("t6_restart_delivered", 64'((npop - p0) >= 2), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the instruction decoder. Owns the PC and issues word fetches to instruction memory over a request/response handshake, one request outstanding at a time.
- Buffers returned instructions in a small in-order queue and presents the queue head (instruction + its PC) to the decoder with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage. A redirect flushes the queue and discards any in-flight response.

Parameters:
- ADDR_WIDTH, 17: instruction address width in bits.
- LEN, 32: instruction and data word width.
- IQ_DEPTH, 4: instruction queue entries (power of two, >=2).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- chip_enabled  input  1  when 0, no new fetch requests issue; queue and outputs hold.
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts request this cycle.
- mem_req_addr  output  ADDR_WIDTH  word-aligned fetch address.
- mem_resp_valid  input  1  one-cycle pulse, response data valid.
- mem_resp_data  input  LEN  fetched instruction.
- inst_valid  output  1  queue head valid toward decoder.
- inst_ready  input  1  decoder consumes head this cycle.
- instruction  output  LEN  queue head instruction.
- inst_pc  output  ADDR_WIDTH  PC of queue head.
- redirect_valid  input  1  branch/jump taken, single-cycle pulse.
- redirect_target  input  ADDR_WIDTH  new PC; bits [1:0] ignored (forced 0).

Behaviour:
- Reset (rst=0, immediate, async):
  - fetch_pc=RESET_PC; queue count, head and tail = 0; FSM=IDLE.
  - mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0.
  - Reset mid-operation aborts any in-flight request. A response pulse arriving while in IDLE is ignored.
- FSM states:
  - IDLE: mem_req_valid = chip_enabled && (count < IQ_DEPTH) && !redirect_valid. mem_req_addr = fetch_pc.
    - On mem_req_valid && mem_req_ready: record req_pc=fetch_pc, fetch_pc += 4 (wraps modulo 2^ADDR_WIDTH), go to WAIT.
  - WAIT: mem_req_valid=0.
    - On mem_resp_valid without redirect: push {mem_resp_data, req_pc} into the queue, go to IDLE.
    - On redirect_valid without a response in the same cycle: go to DISCARD.
    - On redirect_valid and mem_resp_valid in the same cycle: drop the data, go to IDLE.
  - DISCARD: mem_req_valid=0. On mem_resp_valid: drop the data, go to IDLE. Another redirect here only updates fetch_pc.
- Slot reservation: a request issues only when count < IQ_DEPTH. Because at most one request is outstanding, a push can never overflow the queue.
- Push and pop in the same cycle are allowed at any occupancy. Count is unchanged in that case.
- Output: inst_valid = (count != 0); instruction and inst_pc are the head entry, both registered storage.
  - Pop occurs when inst_valid && inst_ready.
  - Latency: a response captured at edge N is visible at inst_valid after edge N. Minimum request-to-decoder time is memory latency + 1 cycle.
- Redirect (redirect_valid=1 at an edge):
  - Queue is flushed (count=0); any simultaneous pop or push is cancelled.
  - fetch_pc = {redirect_target[ADDR_WIDTH-1:2], 2'b00}.
  - inst_valid is 0 in the following cycle.
  - mem_req_valid is forced 0 during the redirect cycle, so no request ever uses a stale PC.
- chip_enabled=0:
  - No new request issues.
  - An outstanding response is still captured (WAIT/DISCARD proceed normally).
  - Decoder handshake continues.
- mem_req_valid, once asserted in IDLE, stays asserted with a stable address until accepted, unless a redirect occurs.

Test Plan:
- Reset release, mem_req_ready=1, 1-cycle response latency, inst_ready=1, memory returns addr*2: requests at 0, 4, 8. Decoder receives instruction=0x0 at inst_pc=0, then 0x8 at inst_pc=4, 0x10 at inst_pc=8, in order with no gaps after the first.
- inst_ready=0, IQ_DEPTH=4: exactly 4 requests (0, 4, 8, 12) issue, then mem_req_valid stays 0. After inst_ready=1, the pop frees a slot and a request at 16 issues the next cycle.
- Redirect to 0x103 while 3 entries are queued and no request is outstanding: inst_valid=0 the next cycle. The next request address is 0x100 and the first delivered inst_pc is 0x100.
- Redirect in WAIT with the response arriving 2 cycles later: the response is dropped, FSM passes through DISCARD, and the next request is at the target address.
- Redirect and mem_resp_valid in the same cycle: the data is not enqueued, and the next request is issued to the target the following cycle.
- Assert rst=0 asynchronously mid-WAIT, release it, then deliver a stale mem_resp_valid pulse: outputs hold their reset values, the stale response is ignored, and the fetch restarts at RESET_PC.
